// File: rtl/radix_pkg.sv
// Shared pipeline definitions for the radix core: data/register geometry,
// instruction-class encodings and the register-file commit qualifier.
package radix_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    INSTR_R = 2'd0,
    INSTR_I = 2'd1,
    INSTR_S = 2'd2
  } instr_type_e;

  // A WB slot writes the file only when it is live, wants a write and is not x0.
  function automatic logic rf_wr_ok(input logic valid, input logic we,
                                    input logic [REG_IDX_W-1:0] rd);
    return valid & we & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_stage_regfile.sv
// Architectural register file: 2 combinational read ports, 1 synchronous write
// port, x0 hardwired to zero. Define WB_BYPASS_EN for write-through reads.
module regfile
  import radix_pkg::*;
#(
  parameter int XLEN  = radix_pkg::XLEN,
  parameter int NREGS = radix_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val
);

  logic [NREGS-1:0][XLEN-1:0] regs;

  // Entry 0 is only ever reset, so it stays zero; reads also force it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (we && wr_idx == REG_IDX_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];
`ifdef WB_BYPASS_EN
    // we already excludes x0, so the bypass cannot leak a value onto index 0.
    if (we && rs1_idx == wr_idx) rs1_val = wr_data;
    if (we && rs2_idx == wr_idx) rs2_val = wr_data;
`endif
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, commit into the register file, forwarding
// tap and retired-instruction counter. WB_BYPASS_EN enables read write-through.
module wb_stage
  import radix_pkg::*;
#(
  parameter int XLEN  = radix_pkg::XLEN,
  parameter int NREGS = radix_pkg::NREGS,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [XLEN-1:0]      writeback_val,
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic                 reg_we_in,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_rd,
  output logic [XLEN-1:0]      fwd_val,
  output logic [CNT_W-1:0]     retired_cnt
);

  logic                 wb_valid;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_val;
  logic                 commit_we;

  // Stall/flush only gate the capture; the slot already in WB commits regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_val   <= '0;
    end else if (stall || flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else begin
      wb_valid <= valid_in;
      wb_we    <= valid_in & reg_we_in;
      wb_rd    <= rd_idx;
      wb_val   <= writeback_val;
    end
  end

  // Stores retire too; the counter wraps freely.
  always_ff @(posedge clk) begin
    if (rst)           retired_cnt <= '0;
    else if (wb_valid) retired_cnt <= retired_cnt + CNT_W'(1);
  end

  assign commit_we = rf_wr_ok(wb_valid, wb_we, wb_rd);
  assign fwd_valid = commit_we;
  assign fwd_rd    = wb_rd;
  assign fwd_val   = wb_val;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (commit_we),
    .wr_idx  (wb_rd),
    .wr_data (wb_val),
    .rs1_idx (rs1_idx),
    .rs2_idx (rs2_idx),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push hand-computed expectations,
// negedge monitor compares read ports, counter and forwarding tap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, stall, flush, reg_we_in;
  logic [31:0] writeback_val;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val, fwd_val;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [3:0]  retired_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .stall         (stall),
    .flush         (flush),
    .writeback_val (writeback_val),
    .rd_idx        (rd_idx),
    .reg_we_in     (reg_we_in),
    .rs1_idx       (rs1_idx),
    .rs2_idx       (rs2_idx),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_val       (fwd_val),
    .retired_cnt   (retired_cnt)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] e1, e2;
    logic [3:0]  ec;
    bit          ef;
  } exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } fwd_t;

  exp_t exp_q[$];
  fwd_t fwd_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] byp(input logic [31:0] with_byp, input logic [31:0] no_byp);
    return BYP ? with_byp : no_byp;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, plus forwarding scoreboard on fwd_valid.
  exp_t m_e;
  fwd_t m_f;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk({m_e.nm, ".rs1"}, rs1_val, m_e.e1);
      chk({m_e.nm, ".rs2"}, rs2_val, m_e.e2);
      chk({m_e.nm, ".cnt"}, 32'(retired_cnt), 32'(m_e.ec));
      chk({m_e.nm, ".fwd_valid"}, 32'(fwd_valid), 32'(m_e.ef));
    end
    if (fwd_valid === 1'b1) begin
      if (fwd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwd_unexpected: got rd=%0d val=%h required no forward", fwd_rd, fwd_val);
      end else begin
        m_f = fwd_q.pop_front();
        chk("fwd_rd", 32'(fwd_rd), 32'(m_f.rd));
        chk("fwd_val", fwd_val, m_f.val);
      end
    end
  end

  task automatic fwd_exp(input logic [4:0] rd, input logic [31:0] val);
    fwd_q.push_back('{rd, val});
  endtask

  task automatic vec(input string nm, input bit v, input bit st, input bit fl, input bit we,
                     input logic [4:0] rd, input logic [31:0] val,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [3:0] ec, input bit ef);
    valid_in = v; stall = st; flush = fl; reg_we_in = we;
    rd_idx = rd; writeback_val = val; rs1_idx = r1; rs2_idx = r2;
    exp_q.push_back('{nm, e1, e2, ec, ef});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 0; stall = 0; flush = 0; reg_we_in = 0;
    rd_idx = 0; writeback_val = 0; rs1_idx = 0; rs2_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    vec("reset", 0,0,0,0, 5'd0, 32'h0, 5'd5, 5'd0, 32'h0, 32'h0, 4'd0, 0);
    rst = 1'b0;

    // Write x5 and check fwd at T+1, file at T+2
    fwd_exp(5'd5, 32'hDEADBEEF);
    vec("w5_issue", 1,0,0,1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0, 32'h0, 4'd0, 0);
    vec("w5_fwd",   0,0,0,0, 5'd0, 32'h0, 5'd5, 5'd0, byp(32'hDEADBEEF, 32'h0), 32'h0, 4'd0, 1);
    vec("w5_read",  0,0,0,0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 4'd1, 0);

    // x0 guard
    vec("x0_issue", 1,0,0,1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1, 0);
    vec("x0_wb",    0,0,0,0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 4'd1, 0);
    vec("x0_after", 0,0,0,0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 4'd2, 0);

    // Same-cycle read of x7 while 0x2 commits over 0x1
    fwd_exp(5'd7, 32'h1);
    fwd_exp(5'd7, 32'h2);
    vec("x7_old",    1,0,0,1, 5'd7, 32'h1, 5'd0, 5'd0, 32'h0, 32'h0, 4'd2, 0);
    vec("x7_new",    1,0,0,1, 5'd7, 32'h2, 5'd7, 5'd0, byp(32'h1, 32'h0), 32'h0, 4'd2, 1);
    vec("x7_commit", 0,0,0,0, 5'd0, 32'h0, 5'd7, 5'd0, byp(32'h2, 32'h1), 32'h0, 4'd3, 1);
    vec("x7_final",  0,0,0,0, 5'd0, 32'h0, 5'd7, 5'd0, 32'h2, 32'h0, 4'd4, 0);

    // Stall: x3=0x11 in WB commits, stalled 0xAA is dropped
    fwd_exp(5'd3, 32'h11);
    vec("st_pre",  1,0,0,1, 5'd3, 32'h11, 5'd3, 5'd0, 32'h0, 32'h0, 4'd4, 0);
    vec("st",      1,1,0,1, 5'd3, 32'hAA, 5'd3, 5'd0, byp(32'h11, 32'h0), 32'h0, 4'd4, 1);
    vec("st_post", 0,0,0,0, 5'd0, 32'h0, 5'd3, 5'd0, 32'h11, 32'h0, 4'd5, 0);
    vec("st_hold", 0,0,0,0, 5'd0, 32'h0, 5'd3, 5'd0, 32'h11, 32'h0, 4'd5, 0);

    // Flush
    fwd_exp(5'd4, 32'h22);
    vec("fl_pre",  1,0,0,1, 5'd4, 32'h22, 5'd4, 5'd0, 32'h0, 32'h0, 4'd5, 0);
    vec("fl",      1,0,1,1, 5'd3, 32'hAA, 5'd3, 5'd4, 32'h11, byp(32'h22, 32'h0), 4'd5, 1);
    vec("fl_post", 0,0,0,0, 5'd0, 32'h0, 5'd3, 5'd4, 32'h11, 32'h22, 4'd6, 0);

    // Stall and flush together
    fwd_exp(5'd6, 32'h33);
    vec("sf_pre",  1,0,0,1, 5'd6, 32'h33, 5'd6, 5'd0, 32'h0, 32'h0, 4'd6, 0);
    vec("sf",      1,1,1,1, 5'd3, 32'hAA, 5'd3, 5'd6, 32'h11, byp(32'h33, 32'h0), 4'd6, 1);
    vec("sf_post", 0,0,0,0, 5'd0, 32'h0, 5'd3, 5'd6, 32'h11, 32'h33, 4'd7, 0);

    // Reset on the commit edge of x9=0x55
    fwd_exp(5'd9, 32'h55);
    vec("mr_issue", 1,0,0,1, 5'd9, 32'h55, 5'd9, 5'd0, 32'h0, 32'h0, 4'd7, 0);
    rst = 1'b1;
    vec("mr_rst",   0,0,0,0, 5'd0, 32'h0, 5'd9, 5'd0, byp(32'h55, 32'h0), 32'h0, 4'd7, 1);
    rst = 1'b0;
    vec("mr_after", 0,0,0,0, 5'd0, 32'h0, 5'd9, 5'd3, 32'h0, 32'h0, 4'd0, 0);

    // 17 stores wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      vec("wrap", 1,0,0,0, 5'd2, 32'hF0F0F0F0, 5'd2, 5'd0, 32'h0, 32'h0,
          4'((i == 0) ? 0 : i - 1), 0);
    vec("wrap_16", 0,0,0,0, 5'd0, 32'h0, 5'd2, 5'd0, 32'h0, 32'h0, 4'd0, 0);
    vec("wrap_17", 0,0,0,0, 5'd0, 32'h0, 5'd2, 5'd0, 32'h0, 32'h0, 4'd1, 0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    checks++;
    if (fwd_q.size() != 0) begin
      errors++;
      $display("FAIL fwd_missing: got %0d unseen forwards required 0", fwd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory stage.
- Holds the MEM/WB pipeline register and the 32-entry architectural register file.
- Commits memory-stage results (`writeback_val`, `rd_idx`, `reg_we_out`) to the register file.
- Serves two combinational read ports to decode, publishes a forwarding tap for the execute stage, and counts retired instructions.

Parameters:
- XLEN, 32, data width of registers and writeback value
- NREGS, 32, number of architectural registers; index width is $clog2(NREGS)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- valid_in  input  1  memory-stage slot holds a real instruction this cycle
- stall  input  1  hazard unit freezes upstream; WB captures a bubble
- flush  input  1  squash; WB captures a bubble
- writeback_val  input  XLEN  result from memory stage (ALU or load data)
- rd_idx  input  5  destination register index
- reg_we_in  input  1  memory stage requests register write
- rs1_idx  input  5  read port 1 index
- rs2_idx  input  5  read port 2 index
- rs1_val  output  XLEN  read port 1 data
- rs2_val  output  XLEN  read port 2 data
- fwd_valid  output  1  WB register holds a pending write to a non-zero rd
- fwd_rd  output  5  WB register destination index
- fwd_val  output  XLEN  WB register data
- retired_cnt  output  CNT_W  count of committed valid instructions

Behaviour:
- Clocking and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset state (next posedge with `rst`=1):
  - `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_val`=0.
  - All registers cleared to 0; `retired_cnt`=0.
  - `fwd_*` outputs read 0.
- Reset mid-operation: a pending commit at that edge is discarded; reset has priority over every other action.
- Capture (posedge, `rst`=0):
  - If `stall` or `flush`: `wb_valid`<=0, `wb_we`<=0 (bubble); `wb_rd` and `wb_val` are don't-care.
  - Otherwise: `wb_valid`<=`valid_in`, `wb_we`<=`valid_in & reg_we_in`, `wb_rd`<=`rd_idx`, `wb_val`<=`writeback_val`.
- Commit (same posedge, using current WB register contents):
  - If `wb_valid` & `wb_we` & `wb_rd`!=0: `regs[wb_rd]`<=`wb_val`.
  - If `wb_valid`: `retired_cnt`<=`retired_cnt`+1, wrapping modulo 2^CNT_W (no saturation). Non-writing instructions (stores) also retire.
- Latency: values presented at edge T are captured at T and written to the register file at T+1. Readable through the file from cycle T+1 onward (bypass) or from T+2 (no bypass).
- `stall` and `flush` never block the commit of the instruction already in WB.
- `stall` and `flush` both asserted: same as either alone (bubble).
- x0 handling:
  - Writes to index 0 are ignored.
  - `rs*_val` for index 0 is always 0.
  - `fwd_valid`=0 when `wb_rd`=0.
- Forwarding tap: combinational from WB register: `fwd_valid` = `wb_valid & wb_we & (wb_rd!=0)`.
- Reads: combinational; without bypass they return the register-file contents (the old value during the commit cycle).
- `retired_cnt` is a registered output.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if `fwd_valid` and `rsN_idx`==`wb_rd`, `rsN_val`=`wb_val` (write-through), so decode sees the committing value in the same cycle.
- Undefined: no bypass; reads return stored register contents only, and the hazard unit must stall one extra cycle.
- Ports are identical in both builds.

Decomposition:
- Shared package `radix_pkg`: XLEN, NREGS, REG_IDX_W=5, and the `instr_type` encodings used by neighbouring stages (R=0, I=1, S=2).
- One natural sub-module, `regfile`:
  - 2 read ports and 1 write port, synchronous write, combinational read.
  - x0 hardwired to 0.
  - Bypass mux inside, under WB_BYPASS_EN.
- `wb_stage` keeps the pipeline register, commit control and counter.

Test Plan:
- Reset then write: `rst` 1 cycle; present `valid_in`=1, `reg_we_in`=1, `rd_idx`=5, `writeback_val`=0xDEADBEEF. Required: `fwd_valid`=1 with `fwd_rd`=5 in cycle T+1; x5 reads 0xDEADBEEF from T+2; `retired_cnt`=1.
- x0 guard: write 0x12345678 to rd=0. Required: `rs1_val`(0)=0 always; `fwd_valid`=0; `retired_cnt` still increments.
- Same-cycle read/write of x7 (old 0x1, new 0x2) during the commit cycle. Required: `rs1_val`=0x2 with WB_BYPASS_EN, 0x1 without.
- Stall/flush: assert `stall` with `valid_in`=1, rd=3, val=0xAA. Required: x3 unchanged, counter unchanged; an instruction already in WB still commits. Repeat with `flush`, then with both asserted: same result.
- Reset mid-op: capture a write to x9=0x55, assert `rst` on the commit edge. Required: x9=0, `retired_cnt`=0, `fwd_valid`=0.
- Counter wrap: with CNT_W=4, retire 17 valid stores (`reg_we_in`=0). Required: `retired_cnt`=1 and no register changed.
